// File: rtl/operand_mux_arbiter.sv
// Round-robin arbiter sharing the constant-operand mux between fetch (A)
// and ALU (B) requesters; optional bounded lock, registered mux drive.
module operand_mux_arbiter #(
    parameter int WIDTH   = 17,
    parameter int MAXHOLD = 4
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             ReqA,
    input  logic [1:0]       SelA,
    input  logic [WIDTH-1:0] DataA,
    input  logic             LockA,
    input  logic             ReqB,
    input  logic [1:0]       SelB,
    input  logic [WIDTH-1:0] DataB,
    input  logic             LockB,
    output logic             GntA,
    output logic             GntB,
    output logic [WIDTH-1:0] MuxInput,
    output logic [1:0]       MuxSelection,
    output logic             MuxValid,
    output logic             SelError
);

    localparam int HW = (MAXHOLD > 1) ? $clog2(MAXHOLD) : 1;
    localparam logic [HW-1:0] HMAX = HW'(MAXHOLD - 1);

    typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} state_t;

    state_t        state;
    logic [HW-1:0] hold;
    logic          last_b;

    logic          win_a;
    logic          win_b;
    logic [HW-1:0] nxt_hold;
    logic [1:0]    win_sel;
    logic [WIDTH-1:0] win_data;
    logic          hold_max;

    assign hold_max = (hold == HMAX);

    always_comb begin
        win_a    = 1'b0;
        win_b    = 1'b0;
        nxt_hold = '0;
        unique case (state)
            GRANT_A: begin
                if (ReqB && (!(ReqA && LockA) || hold_max)) begin
                    win_b = 1'b1;
                end else if (ReqA) begin
                    win_a = 1'b1;
                    if (LockA)
                        nxt_hold = hold_max ? hold : hold + 1'b1;
                end
            end
            GRANT_B: begin
                if (ReqA && (!(ReqB && LockB) || hold_max)) begin
                    win_a = 1'b1;
                end else if (ReqB) begin
                    win_b = 1'b1;
                    if (LockB)
                        nxt_hold = hold_max ? hold : hold + 1'b1;
                end
            end
            default: begin
                // tie goes to whoever did not own the mux last
                if (ReqA && (!ReqB || last_b))
                    win_a = 1'b1;
                else if (ReqB)
                    win_b = 1'b1;
            end
        endcase
    end

    assign win_sel  = win_a ? SelA : SelB;
    assign win_data = win_a ? DataA : DataB;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= IDLE;
            hold         <= '0;
            last_b       <= 1'b1;
            GntA         <= 1'b0;
            GntB         <= 1'b0;
            MuxValid     <= 1'b0;
            MuxInput     <= '0;
            MuxSelection <= 2'd0;
            SelError     <= 1'b0;
        end else begin
            state    <= win_a ? GRANT_A : (win_b ? GRANT_B : IDLE);
            hold     <= nxt_hold;
            GntA     <= win_a;
            GntB     <= win_b;
            MuxValid <= win_a | win_b;
            SelError <= (win_a | win_b) && (win_sel == 2'd3);
            if (win_a)
                last_b <= 1'b0;
            else if (win_b)
                last_b <= 1'b1;
            // illegal code 3 degrades to forcing zero
            if (win_a | win_b) begin
                MuxInput     <= win_data;
                MuxSelection <= (win_sel == 2'd3) ? 2'd1 : win_sel;
            end
        end
    end

endmodule

// File: tb/tb_operand_mux_arbiter.sv
// Directed bench for operand_mux_arbiter: reset, single grant, round robin,
// bounded lock, illegal select, saturating hold and asynchronous reset.
module tb_operand_mux_arbiter;

    localparam int W = 17;

    logic         Clock;
    logic         Reset_n;
    logic         ReqA, LockA, ReqB, LockB;
    logic [1:0]   SelA, SelB;
    logic [W-1:0] DataA, DataB;
    logic         GntA, GntB, MuxValid, SelError;
    logic [W-1:0] MuxInput;
    logic [1:0]   MuxSelection;

    int checks = 0;
    int errors = 0;

    operand_mux_arbiter #(.WIDTH(W), .MAXHOLD(4)) dut (
        .Clock(Clock), .Reset_n(Reset_n),
        .ReqA(ReqA), .SelA(SelA), .DataA(DataA), .LockA(LockA),
        .ReqB(ReqB), .SelB(SelB), .DataB(DataB), .LockB(LockB),
        .GntA(GntA), .GntB(GntB), .MuxInput(MuxInput),
        .MuxSelection(MuxSelection), .MuxValid(MuxValid),
        .SelError(SelError)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic clear_inputs();
        ReqA = 0; LockA = 0; SelA = 0; DataA = '0;
        ReqB = 0; LockB = 0; SelB = 0; DataB = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        Reset_n = 0;
        @(negedge Clock);
        @(negedge Clock);
        Reset_n = 1;
    endtask

    task automatic test_reset();
        logic [5:0] obs;
        clear_inputs();
        Reset_n = 0;
        @(negedge Clock);
        obs = {GntA, GntB, MuxValid, SelError, MuxSelection};
        checks++;
        if (obs !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl got=%b exp=000000", obs);
        end
        checks++;
        if (MuxInput !== '0) begin
            errors++;
            $display("FAIL reset_data got=%h exp=0", MuxInput);
        end
        @(negedge Clock);
        Reset_n = 1;
    endtask

    task automatic test_single();
        logic [5:0] obs;
        do_reset();
        ReqA = 1; SelA = 2'd0; DataA = 17'h1ABCD;
        step();
        ReqA = 0; DataA = 17'h00111;
        obs = {GntA, GntB, MuxValid, SelError, MuxSelection};
        checks++;
        if (obs !== 6'b101000) begin
            errors++;
            $display("FAIL single_ctrl got=%b exp=101000", obs);
        end
        checks++;
        if (MuxInput !== 17'h1ABCD) begin
            errors++;
            $display("FAIL single_data got=%h exp=1abcd", MuxInput);
        end
        step();
        obs = {GntA, GntB, MuxValid, SelError, MuxSelection};
        checks++;
        if (obs !== 6'b000000) begin
            errors++;
            $display("FAIL single_idle got=%b exp=000000", obs);
        end
        checks++;
        if (MuxInput !== 17'h1ABCD) begin
            errors++;
            $display("FAIL single_hold got=%h exp=1abcd", MuxInput);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0]   eg;
        logic [1:0]   es;
        logic [W-1:0] ed;
        do_reset();
        ReqA = 1; SelA = 2'd2; DataA = 17'h0AAAA;
        ReqB = 1; SelB = 2'd1; DataB = 17'h15555;
        for (int i = 0; i < 6; i++) begin
            step();
            eg = (i % 2 == 0) ? 2'b10 : 2'b01;
            es = (i % 2 == 0) ? 2'd2 : 2'd1;
            ed = (i % 2 == 0) ? 17'h0AAAA : 17'h15555;
            checks++;
            if ({GntA, GntB} !== eg || MuxSelection !== es) begin
                errors++;
                $display("FAIL rr_grant[%0d] got=%b/%0d exp=%b/%0d",
                         i, {GntA, GntB}, MuxSelection, eg, es);
            end
            checks++;
            if (MuxInput !== ed) begin
                errors++;
                $display("FAIL rr_data[%0d] got=%h exp=%h", i, MuxInput, ed);
            end
        end
    endtask

    task automatic test_lock();
        logic [8:0] exp_a;
        logic [1:0] eg;
        exp_a = 9'b111101111;
        do_reset();
        ReqA = 1; LockA = 1; SelA = 2'd0; DataA = 17'h00A0A;
        ReqB = 1; SelB = 2'd2; DataB = 17'h00B0B;
        for (int i = 0; i < 9; i++) begin
            step();
            eg = exp_a[8 - i] ? 2'b10 : 2'b01;
            checks++;
            if ({GntA, GntB, MuxValid} !== {eg, 1'b1}) begin
                errors++;
                $display("FAIL lock_seq[%0d] got=%b exp=%b1",
                         i, {GntA, GntB, MuxValid}, eg);
            end
        end
    endtask

    task automatic test_sel_error();
        logic [5:0] obs;
        do_reset();
        ReqB = 1; SelB = 2'd3; DataB = 17'h00005;
        step();
        ReqB = 0;
        obs = {GntA, GntB, MuxValid, SelError, MuxSelection};
        checks++;
        if (obs !== 6'b011101) begin
            errors++;
            $display("FAIL selerr_ctrl got=%b exp=011101", obs);
        end
        checks++;
        if (MuxInput !== 17'h00005) begin
            errors++;
            $display("FAIL selerr_data got=%h exp=00005", MuxInput);
        end
        step();
        checks++;
        if (SelError !== 1'b0 || MuxValid !== 1'b0) begin
            errors++;
            $display("FAIL selerr_pulse got=%b%b exp=00", SelError, MuxValid);
        end
    endtask

    task automatic test_lock_alone();
        int gaps;
        do_reset();
        ReqA = 1; LockA = 1; SelA = 2'd1; DataA = 17'h01234;
        gaps = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (GntA !== 1'b1 || MuxValid !== 1'b1)
                gaps++;
        end
        checks++;
        if (gaps !== 0) begin
            errors++;
            $display("FAIL lock_alone_gaps got=%0d exp=0", gaps);
        end
        // saturated hold lets a new contender in on the very next edge
        ReqB = 1; SelB = 2'd0; DataB = 17'h0BEEF;
        step();
        checks++;
        if ({GntA, GntB} !== 2'b01 || MuxInput !== 17'h0BEEF) begin
            errors++;
            $display("FAIL lock_alone_sat got=%b/%h exp=01/0beef",
                     {GntA, GntB}, MuxInput);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        ReqB = 1; SelB = 2'd2; DataB = 17'h1F00F;
        step();
        checks++;
        if (GntB !== 1'b1 || MuxInput !== 17'h1F00F) begin
            errors++;
            $display("FAIL mid_pre got=%b/%h exp=1/1f00f", GntB, MuxInput);
        end
        #2;
        Reset_n = 0;
        #1;
        checks++;
        if ({GntB, MuxValid} !== 2'b00 || MuxInput !== '0) begin
            errors++;
            $display("FAIL mid_async got=%b/%h exp=00/00000",
                     {GntB, MuxValid}, MuxInput);
        end
        ReqA = 1; SelA = 2'd0; DataA = 17'h00077;
        @(negedge Clock);
        Reset_n = 1;
        step();
        checks++;
        if ({GntA, GntB} !== 2'b10 || MuxInput !== 17'h00077) begin
            errors++;
            $display("FAIL mid_first got=%b/%h exp=10/00077",
                     {GntA, GntB}, MuxInput);
        end
    endtask

    initial begin
        clear_inputs();
        Reset_n = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_lock();
        test_sel_error();
        test_lock_alone();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
